psum_requant: RTL and testbench
===============================

Name: psum_requant

Overview:
- Sits directly downstream of the systolic MAC array. Consumes its per-column partial sums (COLUMN lanes of signed OW-bit values) over a first..last group of beats.
- Accumulates each group into a wide per-lane accumulator, adds a per-channel bias, then rounds, shifts, applies optional ReLU and saturates to signed 8-bit activations.
- Emits one COLUMN-wide activation word per group toward the output buffer / next CONV layer.

Parameters:
- COLUMN, 6, number of parallel output lanes (matches MAC array columns)
- IW, 22, width of each signed input partial sum (2*DW+6 with DW=8)
- AW, 32, width of each signed accumulator lane
- BW, 16, width of each signed bias value
- QW, 8, width of each signed output activation
- SW, 5, width of the shift-amount field

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rq_m_data  in  COLUMN*IW  signed partial sums, lane j at [j*IW +: IW]
- rq_m_first  in  1  first beat of a group
- rq_m_last  in  1  last beat of a group
- rq_m_valid  in  1  input beat valid
- rq_m_ready  out  1  input beat accepted when valid&&ready
- bias  in  COLUMN*BW  signed per-lane bias, sampled on accepted first beat
- shift  in  SW  right-shift amount 0..31, sampled on accepted first beat
- relu_en  in  1  clamp negatives to 0, sampled on accepted first beat
- rq_s_data  out  COLUMN*QW  signed activations, lane j at [j*QW +: QW]
- rq_s_valid  out  1  output word valid
- rq_s_ready  in  1  downstream ready
- ovf  out  1  sticky: any accumulator or output saturation since reset

Behaviour:
- Reset: all outputs 0, rq_m_ready 0 while rst is high, then 1 on the first cycle after release. Accumulators, config registers, ovf and rq_s_valid are cleared.
- Handshake:
  - rq_m_ready = !(rq_s_valid && !rq_s_ready). It is combinational, allowing full-throughput back-to-back groups.
  - A beat transfers only when rq_m_valid && rq_m_ready. Data and flags are held otherwise.
- Accumulate per lane on an accepted beat. Let x be the input lane, sign-extended to AW, and b be bias, sign-extended to AW.
  - first=1: acc_next = b + x. bias, shift and relu_en are latched into config registers.
  - first=0: acc_next = acc + x.
  - The add saturates at signed AW limits. Saturation sets ovf.
- Requantize, on an accepted beat with last=1, per lane from acc_next:
  - Config used is the latched value, or the live value if the same beat has first=1.
  - If s>0: r = (acc_next + (1<<(s-1))) >>> s, i.e. arithmetic shift with round-half-up. If s=0: r = acc_next.
  - If relu_en: r = max(r,0).
  - Saturate r to [-128,127]. Clamping sets ovf.
  - Result is registered into rq_s_data; rq_s_valid=1 on the next edge. Latency: accepted last beat at edge N gives rq_s_valid high after edge N.
- Output:
  - rq_s_data and rq_s_valid hold until rq_s_ready.
  - On rq_s_ready with no new last beat, rq_s_valid drops.
  - If a new last beat is accepted in the same cycle as a drain, the output register reloads and rq_s_valid stays 1.
- Boundary conditions:
  - first && last on the same beat: single-beat group, result = quant(bias + x).
  - first arriving mid-group: the partial is discarded and the group restarts. No error is raised.
  - Beat with first=0 directly after reset: accumulates onto 0 with bias 0, shift 0, relu 0.
  - After last, the accumulator is not cleared; the next group must begin with first.
  - ovf is cleared only by rst.
  - rst asserted mid-group: the group is lost, outputs clear immediately, and no partial output is emitted.

Test Plan:
- Single beat: first=last=1, all lanes x=100, bias=28, shift=2, relu=0 -> rq_s_valid next cycle, each lane 32 ((128+2)>>>2), ovf=0.
- 3-beat group: lane0 x=+50,+60,+70, bias=-30, shift=1 -> lane0 = (150+1)>>>1 = 75. Lane1 x=-10 each, bias 0, relu_en=1 -> lane1 = 0.
- Saturation: x=+1000 three beats, shift=0 -> lane 127 and ovf=1. x=-1000, relu=0 -> lane -128.
- Backpressure: hold rq_s_ready=0 with an output pending. rq_m_ready=0, input beats stall, rq_s_data stable. Release -> output drains, and a next last beat reloads the output in the same cycle with no bubble.
- Mid-group restart: first, beat, then a new first with x=5, last, bias 0, shift 0 -> output 5; the earlier partial is ignored.
- Reset mid-group: assert rst after 2 beats -> rq_s_valid=0, ovf=0 immediately. A new single-beat group after release gives the correct value.

Source files
------------

// File: rtl/psum_requant.sv
// psum_requant: accumulates grouped partial sums from the systolic MAC array
// per output lane, folds in a per-channel bias, then rounds, shifts, applies
// optional ReLU and saturates each lane to a signed QW-bit activation.
module psum_requant #(
  parameter int COLUMN = 6,
  parameter int IW     = 22,
  parameter int AW     = 32,
  parameter int BW     = 16,
  parameter int QW     = 8,
  parameter int SW     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [COLUMN*IW-1:0] rq_m_data,
  input  logic                 rq_m_first,
  input  logic                 rq_m_last,
  input  logic                 rq_m_valid,
  output logic                 rq_m_ready,
  input  logic [COLUMN*BW-1:0] bias,
  input  logic [SW-1:0]        shift,
  input  logic                 relu_en,
  output logic [COLUMN*QW-1:0] rq_s_data,
  output logic                 rq_s_valid,
  input  logic                 rq_s_ready,
  output logic                 ovf
);

  localparam logic signed [AW:0] QMAX = (AW+1)'((1 << (QW-1)) - 1);
  localparam logic signed [AW:0] QMIN = ~QMAX;

  // Clamp an AW+1-bit sum back into the signed AW-bit accumulator range.
  function automatic logic signed [AW-1:0] sat_acc(input logic signed [AW:0] v);
    if (v[AW] != v[AW-1])
      sat_acc = v[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    else
      sat_acc = v[AW-1:0];
  endfunction

  // Arithmetic right shift with round-half-up, then optional ReLU. One extra
  // bit of headroom keeps the rounding increment from wrapping at +max.
  function automatic logic signed [AW:0] round_shift(input logic signed [AW-1:0] a,
                                                     input logic [SW-1:0] s,
                                                     input logic relu);
    logic signed [AW:0] ext;
    logic signed [AW:0] half;
    logic signed [AW:0] r;
    ext = {a[AW-1], a};
    if (s == '0) begin
      r = ext;
    end else begin
      half = (AW+1)'(1) <<< (s - SW'(1));
      r    = (ext + half) >>> s;
    end
    if (relu && r[AW])
      r = '0;
    round_shift = r;
  endfunction

  // Saturate the shifted value to the signed QW-bit activation range.
  function automatic logic [QW-1:0] sat_q(input logic signed [AW:0] v);
    if (v > QMAX)
      sat_q = QMAX[QW-1:0];
    else if (v < QMIN)
      sat_q = QMIN[QW-1:0];
    else
      sat_q = v[QW-1:0];
  endfunction

  logic signed [AW-1:0] r_acc [COLUMN];
  logic [SW-1:0]        r_shift;
  logic                 r_relu;
  logic [COLUMN*QW-1:0] r_data_p1;
  logic                 r_vld_p1;
  logic                 r_ovf;

  logic                 w_ready_p0;
  logic                 w_fire_p0;
  logic [SW-1:0]        w_shift_p0;
  logic                 w_relu_p0;
  logic signed [AW-1:0] w_acc_next_p0 [COLUMN];
  logic [COLUMN-1:0]    w_acc_ovf_p0;
  logic [COLUMN-1:0]    w_q_ovf_p0;
  logic [COLUMN*QW-1:0] w_q_word_p0;
  logic                 w_ovf_hit_p0;

  // A held output blocks new input; rst forces not-ready for its duration.
  assign w_ready_p0 = !rst && !(r_vld_p1 && !rq_s_ready);
  assign w_fire_p0  = rq_m_valid && w_ready_p0;

  // A first beat brings its own config; later beats use the latched copy.
  assign w_shift_p0 = rq_m_first ? shift   : r_shift;
  assign w_relu_p0  = rq_m_first ? relu_en : r_relu;

  // ---- stage p0: accumulate and requantize, per lane ----
  for (genvar j = 0; j < COLUMN; j++) begin : g_lane
    logic signed [IW-1:0] w_x;
    logic signed [BW-1:0] w_b;
    logic signed [AW:0]   w_base;
    logic signed [AW:0]   w_sum;
    logic signed [AW:0]   w_rs;

    assign w_x    = rq_m_data[j*IW +: IW];
    assign w_b    = bias[j*BW +: BW];
    // Bias is folded in on the first beat, so it never needs its own register.
    assign w_base = rq_m_first ? {{(AW+1-BW){w_b[BW-1]}}, w_b}
                               : {r_acc[j][AW-1], r_acc[j]};
    assign w_sum  = w_base + {{(AW+1-IW){w_x[IW-1]}}, w_x};

    assign w_acc_ovf_p0[j]  = w_sum[AW] ^ w_sum[AW-1];
    assign w_acc_next_p0[j] = sat_acc(w_sum);
    assign w_rs             = round_shift(w_acc_next_p0[j], w_shift_p0, w_relu_p0);
    assign w_q_ovf_p0[j]    = (w_rs > QMAX) || (w_rs < QMIN);
    assign w_q_word_p0[j*QW +: QW] = sat_q(w_rs);
  end

  assign w_ovf_hit_p0 = (|w_acc_ovf_p0) || (rq_m_last && (|w_q_ovf_p0));

  // Per-lane accumulators update on every accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < COLUMN; j++) r_acc[j] <= '0;
    end else if (w_fire_p0) begin
      for (int j = 0; j < COLUMN; j++) r_acc[j] <= w_acc_next_p0[j];
    end
  end

  // Shift and ReLU settings are captured on an accepted first beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_relu  <= 1'b0;
    end else if (w_fire_p0 && rq_m_first) begin
      r_shift <= shift;
      r_relu  <= relu_en;
    end
  end

  // ---- stage p1: output register, reloads on a last beat even while draining ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_p1 <= '0;
      r_vld_p1  <= 1'b0;
    end else if (w_fire_p0 && rq_m_last) begin
      r_data_p1 <= w_q_word_p0;
      r_vld_p1  <= 1'b1;
    end else if (rq_s_ready) begin
      r_vld_p1  <= 1'b0;
    end
  end

  // Sticky saturation flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ovf <= 1'b0;
    else if (w_fire_p0 && w_ovf_hit_p0)
      r_ovf <= 1'b1;
  end

  assign rq_m_ready = w_ready_p0;
  assign rq_s_data  = r_data_p1;
  assign rq_s_valid = r_vld_p1;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_psum_requant.sv
// Directed bench for psum_requant with hand-computed expected activations.
module tb_psum_requant;

  localparam int COLUMN = 6;
  localparam int IW     = 22;
  localparam int AW     = 32;
  localparam int BW     = 16;
  localparam int QW     = 8;
  localparam int SW     = 5;

  logic                 clk;
  logic                 rst;
  logic [COLUMN*IW-1:0] rq_m_data;
  logic                 rq_m_first;
  logic                 rq_m_last;
  logic                 rq_m_valid;
  logic                 rq_m_ready;
  logic [COLUMN*BW-1:0] bias;
  logic [SW-1:0]        shift;
  logic                 relu_en;
  logic [COLUMN*QW-1:0] rq_s_data;
  logic                 rq_s_valid;
  logic                 rq_s_ready;
  logic                 ovf;

  int n_chk = 0;
  int n_err = 0;

  psum_requant #(
    .COLUMN(COLUMN), .IW(IW), .AW(AW), .BW(BW), .QW(QW), .SW(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .rq_m_data(rq_m_data), .rq_m_first(rq_m_first), .rq_m_last(rq_m_last),
    .rq_m_valid(rq_m_valid), .rq_m_ready(rq_m_ready),
    .bias(bias), .shift(shift), .relu_en(relu_en),
    .rq_s_data(rq_s_data), .rq_s_valid(rq_s_valid), .rq_s_ready(rq_s_ready),
    .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [QW-1:0] q_lane(input int j);
    return rq_s_data[j*QW +: QW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_x(input int j, input int v);
    rq_m_data[j*IW +: IW] = IW'(v);
  endtask

  task automatic set_all_x(input int v);
    for (int j = 0; j < COLUMN; j++) set_x(j, v);
  endtask

  task automatic set_b(input int j, input int v);
    bias[j*BW +: BW] = BW'(v);
  endtask

  task automatic set_all_b(input int v);
    for (int j = 0; j < COLUMN; j++) set_b(j, v);
  endtask

  // One accepted beat (ready is expected to be high).
  task automatic beat(input logic f, input logic l);
    rq_m_first = f;
    rq_m_last  = l;
    rq_m_valid = 1'b1;
    tick();
    rq_m_valid = 1'b0;
    rq_m_first = 1'b0;
    rq_m_last  = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    rq_m_data  = '0;
    rq_m_first = 1'b0;
    rq_m_last  = 1'b0;
    rq_m_valid = 1'b0;
    bias       = '0;
    shift      = '0;
    relu_en    = 1'b0;
    rq_s_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_m_ready", rq_m_ready, 0);
    check("rst_s_valid", rq_s_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_data", rq_s_data, 0);
    rst = 1'b0;
    #1;
    check("post_rst_m_ready", rq_m_ready, 1);

    // first=0 right after reset: acc 0, bias/shift/relu zero; live config ignored
    set_all_x(9);
    set_x(5, -3);
    set_all_b(50);
    shift   = 5'd3;
    relu_en = 1'b1;
    beat(1'b0, 1'b1);
    check("nofirst_vld", rq_s_valid, 1);
    check("nofirst_l0", q_lane(0), 9);
    check("nofirst_l5", q_lane(5), -3);

    // Single beat: (100+28+2)>>>2 = 32 on every lane
    set_all_x(100);
    set_all_b(28);
    shift   = 5'd2;
    relu_en = 1'b0;
    beat(1'b1, 1'b1);
    check("t1_vld", rq_s_valid, 1);
    for (int j = 0; j < COLUMN; j++) check($sformatf("t1_l%0d", j), q_lane(j), 32);
    check("t1_ovf", ovf, 0);
    tick();
    check("t1_drain_vld", rq_s_valid, 0);

    // 3-beat group, config latched on first; later live config is junk
    set_all_x(0);
    set_all_b(0);
    set_x(0, 50);  set_b(0, -30);
    set_x(1, -10);
    shift   = 5'd1;
    relu_en = 1'b1;
    beat(1'b1, 1'b0);
    check("t2_b1_vld", rq_s_valid, 0);
    shift   = 5'd7;
    relu_en = 1'b0;
    set_all_b(1000);
    set_x(0, 60);
    beat(1'b0, 1'b0);
    check("t2_b2_vld", rq_s_valid, 0);
    set_x(0, 70);
    beat(1'b0, 1'b1);
    check("t2_vld", rq_s_valid, 1);
    check("t2_l0", q_lane(0), 75);
    check("t2_l1", q_lane(1), 0);
    check("t2_l2", q_lane(2), 0);
    check("t2_ovf", ovf, 0);

    // Saturation: 3000 -> 127, -3000 -> -128, ovf sets
    set_all_x(0);
    set_all_b(0);
    set_x(0, 1000);
    set_x(1, -1000);
    shift   = 5'd0;
    relu_en = 1'b0;
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    check("t3_ovf_early", ovf, 0);
    beat(1'b0, 1'b1);
    check("t3_l0", q_lane(0), 127);
    check("t3_l1", q_lane(1), -128);
    check("t3_l2", q_lane(2), 0);
    check("t3_ovf", ovf, 1);
    tick();

    // Backpressure: held output stalls input, then drain+reload with no bubble
    set_all_x(4);
    set_all_b(0);
    rq_s_ready = 1'b0;
    beat(1'b1, 1'b1);
    check("t4_vld", rq_s_valid, 1);
    check("t4_l0", q_lane(0), 4);
    check("t4_m_ready", rq_m_ready, 0);
    set_all_x(9);
    rq_m_first = 1'b1;
    rq_m_last  = 1'b1;
    rq_m_valid = 1'b1;
    tick();
    tick();
    check("t4_stall_vld", rq_s_valid, 1);
    check("t4_stall_l0", q_lane(0), 4);
    rq_s_ready = 1'b1;
    #1;
    check("t4_rel_m_ready", rq_m_ready, 1);
    tick();
    check("t4_reload_vld", rq_s_valid, 1);
    check("t4_reload_l0", q_lane(0), 9);
    rq_m_valid = 1'b0;
    rq_m_first = 1'b0;
    rq_m_last  = 1'b0;
    tick();
    check("t4_drain_vld", rq_s_valid, 0);

    // Mid-group restart: earlier partial discarded
    set_all_x(100);
    beat(1'b1, 1'b0);
    set_all_x(200);
    beat(1'b0, 1'b0);
    set_all_x(5);
    beat(1'b1, 1'b1);
    check("t5_vld", rq_s_valid, 1);
    check("t5_l0", q_lane(0), 5);
    check("t5_l4", q_lane(4), 5);
    tick();

    // Reset mid-group: outputs and ovf clear immediately
    set_all_x(3);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_vld", rq_s_valid, 0);
    check("t6_rst_ovf", ovf, 0);
    check("t6_rst_l0", q_lane(0), 0);
    check("t6_rst_m_ready", rq_m_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    // (-7+3) = -4; (-4+1)>>>1 = -2
    set_all_x(-7);
    set_all_b(3);
    shift = 5'd1;
    beat(1'b1, 1'b1);
    check("t6_vld", rq_s_valid, 1);
    check("t6_l0", q_lane(0), -2);
    check("t6_l3", q_lane(3), -2);
    check("t6_ovf", ovf, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
